// File: rtl/mem_tracer.sv
// mem_tracer: snoops a RAM write port and timestamps in-window writes during a
// timed RUN phase, then streams them out of a FWFT FIFO. Optional shadow copy: MEM_TRACE_SHADOW_EN.
module mem_tracer #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WIN_BASE    = 0,
    parameter int WIN_DEPTH   = 9,
    parameter int FIFO_DEPTH  = 8,
    parameter int CYC_W       = 16,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              tr_valid,
    input  logic              tr_ready,
    output logic [ADDR_W-1:0] tr_addr,
    output logic [DATA_W-1:0] tr_data,
    output logic [CYC_W-1:0]  tr_cycle,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic              done,
    output logic [1:0]        state,
    input  logic [7:0]        peek_addr,
    output logic [DATA_W-1:0] peek_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cyc;
    } entry_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0]  WIN_LO    = (ADDR_W+1)'(WIN_BASE);
    localparam logic [ADDR_W:0]  WIN_HI    = (ADDR_W+1)'(WIN_BASE + WIN_DEPTH - 1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             done_q, done_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    entry_t fifo_mem_q [FIFO_DEPTH];
    entry_t entry_d;
    entry_t head;

    logic in_win;
    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign in_win  = wr_en && ({1'b0, wr_addr} >= WIN_LO) && ({1'b0, wr_addr} <= WIN_HI);
    assign capture = (state_q == RUN) && in_win;
    assign full    = (count_q == FIFO_FULL);
    assign pop     = tr_valid && tr_ready;
    // A full FIFO still accepts a capture when the head retires on the same edge.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = RUN;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CYC_LAST) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        done_d = (state_d == DONE);
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop ? sat_inc8(drop_cnt_q) : drop_cnt_q;
        entry_d    = '{addr: wr_addr, data: wr_data, cyc: cyc_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head     = fifo_mem_q[rd_ptr_q];
    assign tr_valid = (count_q != '0);
    assign tr_addr  = tr_valid ? head.addr : '0;
    assign tr_data  = tr_valid ? head.data : '0;
    assign tr_cycle = tr_valid ? head.cyc  : '0;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign done     = done_q;
    assign state    = state_q;

`ifdef MEM_TRACE_SHADOW_EN
    localparam int SH_W = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;

    logic [DATA_W-1:0] shadow_q [WIN_DEPTH];
    logic [DATA_W-1:0] shadow_d [WIN_DEPTH];
    logic [SH_W-1:0]   wr_idx;

    assign wr_idx = SH_W'(wr_addr - ADDR_W'(WIN_BASE));

    // Dropped captures still land in the shadow; it mirrors the RAM, not the trace.
    always_comb begin
        shadow_d = shadow_q;
        if (capture) begin
            shadow_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign peek_data = ({1'b0, peek_addr} < 9'(WIN_DEPTH)) ? shadow_q[peek_addr[SH_W-1:0]] : '0;
`else
    logic unused_peek;
    assign unused_peek = ^peek_addr;
    assign peek_data   = '0;
`endif

endmodule

// File: tb/tb_mem_tracer.sv
// Directed testbench for mem_tracer with default parameters; shadow checks follow MEM_TRACE_SHADOW_EN.
module tb_mem_tracer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        arm;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        tr_valid;
    logic        tr_ready;
    logic [15:0] tr_addr;
    logic [15:0] tr_data;
    logic [15:0] tr_cycle;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        done;
    logic [1:0]  state;
    logic [7:0]  peek_addr;
    logic [15:0] peek_data;

    int n_cmp = 0;
    int n_err = 0;

    mem_tracer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .arm       (arm),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .tr_valid  (tr_valid),
        .tr_ready  (tr_ready),
        .tr_addr   (tr_addr),
        .tr_data   (tr_data),
        .tr_cycle  (tr_cycle),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .done      (done),
        .state     (state),
        .peek_addr (peek_addr),
        .peek_data (peek_data)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n   = 1'b0;
        arm       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        tr_ready  = 1'b0;
        peek_addr = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Leaves the caller at the first negedge in RUN, cycle counter = 0.
    task automatic arm_run();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        arm = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; tr_ready = 1'b0; peek_addr = '0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", tr_valid); end
        n_cmp++; if ({overflow, drop_cnt, done} !== 10'd0) begin n_err++; $display("FAIL rst_flags: got ovf=%b drop=%0d done=%b want 0", overflow, drop_cnt, done); end
        n_cmp++; if ({tr_addr, tr_data, tr_cycle} !== 48'd0) begin n_err++; $display("FAIL rst_tr: got %h %h %h want 0", tr_addr, tr_data, tr_cycle); end
        n_cmp++; if (peek_data !== 16'd0) begin n_err++; $display("FAIL rst_peek: got %h want 0", peek_data); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_capture();
        do_reset();
        arm_run();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL cap_run: got %0d want 1", state); end
        repeat (5) @(negedge clk);
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL cap_empty: got %b want 0", tr_valid); end
        wr_en = 1'b1; wr_addr = 16'd3; wr_data = 16'h00AB; tr_ready = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (tr_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %b want 1", tr_valid); end
        n_cmp++; if (tr_addr !== 16'd3) begin n_err++; $display("FAIL cap_addr: got %h want 0003", tr_addr); end
        n_cmp++; if (tr_data !== 16'h00AB) begin n_err++; $display("FAIL cap_data: got %h want 00ab", tr_data); end
        n_cmp++; if (tr_cycle !== 16'd5) begin n_err++; $display("FAIL cap_cycle: got %0d want 5", tr_cycle); end
        @(negedge clk);
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL cap_retire: got %b want 0", tr_valid); end
        tr_ready = 1'b0;
    endtask

    task automatic test_window();
        do_reset();
        arm_run();
        wr_en = 1'b1; wr_addr = 16'd9; wr_data = 16'h1234;
        @(negedge clk);
        wr_addr = 16'hFFFF; wr_data = 16'h4321;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL win_outside: got %b want 0", tr_valid); end
        peek_addr = 8'd9;
        #1;
        n_cmp++; if (peek_data !== 16'd0) begin n_err++; $display("FAIL win_peek9: got %h want 0", peek_data); end
        wr_en = 1'b1; wr_addr = 16'd8; wr_data = 16'h0808;
        @(negedge clk);
        wr_addr = 16'd0; wr_data = 16'h0100;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if ({tr_valid, tr_addr, tr_data, tr_cycle} !== {1'b1, 16'd8, 16'h0808, 16'd2}) begin
            n_err++; $display("FAIL win_hi_entry: got v=%b %h %h %0d want 1 0008 0808 2", tr_valid, tr_addr, tr_data, tr_cycle);
        end
        peek_addr = 8'd8;
        #1;
`ifdef MEM_TRACE_SHADOW_EN
        n_cmp++; if (peek_data !== 16'h0808) begin n_err++; $display("FAIL win_peek8: got %h want 0808", peek_data); end
        peek_addr = 8'd0;
        #1;
        n_cmp++; if (peek_data !== 16'h0100) begin n_err++; $display("FAIL win_peek0: got %h want 0100", peek_data); end
`else
        n_cmp++; if (peek_data !== 16'd0) begin n_err++; $display("FAIL win_peek_off: got %h want 0", peek_data); end
`endif
        tr_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({tr_valid, tr_addr, tr_data, tr_cycle} !== {1'b1, 16'd0, 16'h0100, 16'd3}) begin
            n_err++; $display("FAIL win_lo_entry: got v=%b %h %h %0d want 1 0000 0100 3", tr_valid, tr_addr, tr_data, tr_cycle);
        end
        @(negedge clk);
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL win_drain: got %b want 0", tr_valid); end
        tr_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        arm_run();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_addr = 16'(i % 9); wr_data = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        n_cmp++; if ({tr_valid, tr_data, tr_cycle} !== {1'b1, 16'h1000, 16'd0}) begin
            n_err++; $display("FAIL ovf_head: got v=%b %h %0d want 1 1000 0", tr_valid, tr_data, tr_cycle);
        end
`ifdef MEM_TRACE_SHADOW_EN
        peek_addr = 8'd8;
        #1;
        n_cmp++; if (peek_data !== 16'h1008) begin n_err++; $display("FAIL ovf_peek8: got %h want 1008", peek_data); end
        peek_addr = 8'd0;
        #1;
        n_cmp++; if (peek_data !== 16'h1009) begin n_err++; $display("FAIL ovf_peek0: got %h want 1009", peek_data); end
`endif
        @(negedge clk);
        n_cmp++; if ({tr_valid, tr_addr, tr_data, tr_cycle} !== {1'b1, 16'd0, 16'h1000, 16'd0}) begin
            n_err++; $display("FAIL ovf_hold: got v=%b %h %h %0d want 1 0000 1000 0", tr_valid, tr_addr, tr_data, tr_cycle);
        end
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'hBEEF; tr_ready = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL ovf_swap_drop: got %0d want 2", drop_cnt); end
        for (int j = 1; j < 8; j++) begin
            n_cmp++; if ({tr_valid, tr_data, tr_cycle} !== {1'b1, 16'h1000 + 16'(j), 16'(j)}) begin
                n_err++; $display("FAIL ovf_order%0d: got v=%b %h %0d want 1 %h %0d", j, tr_valid, tr_data, tr_cycle, 16'h1000 + 16'(j), j);
            end
            @(negedge clk);
        end
        n_cmp++; if ({tr_valid, tr_addr, tr_data, tr_cycle} !== {1'b1, 16'd5, 16'hBEEF, 16'd11}) begin
            n_err++; $display("FAIL ovf_kept: got v=%b %h %h %0d want 1 0005 beef 11", tr_valid, tr_addr, tr_data, tr_cycle);
        end
        @(negedge clk);
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", tr_valid); end
        tr_ready = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        arm_run();
        arm = 1'b1;
        wr_en = 1'b1; wr_addr = 16'd1; wr_data = 16'h0A01;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (98) @(negedge clk);
        n_cmp++; if ({state, done} !== {2'd1, 1'b0}) begin n_err++; $display("FAIL to_before: got st=%0d done=%b want 1 0", state, done); end
        wr_en = 1'b1; wr_addr = 16'd2; wr_data = 16'h0A02;
        @(negedge clk);
        n_cmp++; if ({state, done} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL to_done: got st=%0d done=%b want 2 1", state, done); end
        wr_addr = 16'd3; wr_data = 16'h0A03;
        @(negedge clk);
        wr_en = 1'b0; tr_ready = 1'b1;
        n_cmp++; if ({tr_valid, tr_data, tr_cycle} !== {1'b1, 16'h0A01, 16'd0}) begin
            n_err++; $display("FAIL to_drain1: got v=%b %h %0d want 1 0a01 0", tr_valid, tr_data, tr_cycle);
        end
        @(negedge clk);
        n_cmp++; if ({tr_valid, tr_data, tr_cycle} !== {1'b1, 16'h0A02, 16'd99}) begin
            n_err++; $display("FAIL to_drain2: got v=%b %h %0d want 1 0a02 99", tr_valid, tr_data, tr_cycle);
        end
        @(negedge clk);
        n_cmp++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL to_no_done_cap: got %b want 0", tr_valid); end
        n_cmp++; if ({state, done} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL to_hold: got st=%0d done=%b want 2 1", state, done); end
`ifdef MEM_TRACE_SHADOW_EN
        peek_addr = 8'd3;
        #1;
        n_cmp++; if (peek_data !== 16'd0) begin n_err++; $display("FAIL to_peek3: got %h want 0", peek_data); end
`endif
        arm = 1'b0; tr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        arm_run();
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_addr = 16'(i % 9); wr_data = 16'h2000 + 16'(i);
            @(negedge clk);
        end
        wr_en = 1'b0; tr_ready = 1'b1;
        repeat (4) @(negedge clk);
        tr_ready = 1'b0;
        n_cmp++; if ({tr_valid, tr_data, drop_cnt} !== {1'b1, 16'h2004, 8'd4}) begin
            n_err++; $display("FAIL mid_pending: got v=%b %h drop=%0d want 1 2004 4", tr_valid, tr_data, drop_cnt);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({tr_valid, state, drop_cnt, overflow, done} !== 13'd0) begin
            n_err++; $display("FAIL mid_async: got v=%b st=%0d drop=%0d ovf=%b done=%b want all 0", tr_valid, state, drop_cnt, overflow, done);
        end
        n_cmp++; if ({tr_addr, tr_data, tr_cycle} !== 48'd0) begin n_err++; $display("FAIL mid_tr: got %h %h %h want 0", tr_addr, tr_data, tr_cycle); end
        for (int k = 0; k < 9; k++) begin
            peek_addr = 8'(k);
            #1;
            n_cmp++; if (peek_data !== 16'd0) begin n_err++; $display("FAIL mid_peek%0d: got %h want 0", k, peek_data); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 16'd2; wr_data = 16'h5555;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if ({state, tr_valid} !== 3'b000) begin n_err++; $display("FAIL mid_no_arm: got st=%0d v=%b want 0 0", state, tr_valid); end
        arm_run();
        wr_en = 1'b1; wr_addr = 16'd4; wr_data = 16'h7777;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++; if ({tr_valid, tr_addr, tr_data, tr_cycle} !== {1'b1, 16'd4, 16'h7777, 16'd0}) begin
            n_err++; $display("FAIL mid_rearm: got v=%b %h %h %0d want 1 0004 7777 0", tr_valid, tr_addr, tr_data, tr_cycle);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_window();
        test_overflow();
        test_timeout();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
